// File: rtl/pong_pkg.sv
// Shared Pong types and constants: AI FSM encoding, move-request encoding,
// canvas limits, and the dead-zone hysteresis step used by the AI opponent.
package pong_pkg;

    typedef enum logic [1:0] {
        AI_IDLE  = 2'd0,
        AI_REACT = 2'd1,
        AI_TRACK = 2'd2,
        AI_MISS  = 2'd3
    } ai_state_t;

    localparam logic [1:0] MOVE_NONE = 2'b00;
    localparam logic [1:0] MOVE_DOWN = 2'b01;
    localparam logic [1:0] MOVE_UP   = 2'b10;

    localparam logic [9:0] CANVAS_TOP    = 10'd50;
    localparam logic [9:0] CANVAS_BOTTOM = 10'd450;

    typedef struct packed {
        logic       moving;
        logic [1:0] move;
    } hyst_t;

    // Start moving beyond the dead zone, stop only once inside the tighter stop band.
    function automatic hyst_t hyst_step(input logic              moving,
                                        input logic signed [10:0] err,
                                        input logic [10:0]        deadzone,
                                        input logic [10:0]        stop_band);
        hyst_t      r_res;
        logic [10:0] w_mag;
        w_mag      = err[10] ? 11'(-err) : err;
        r_res.moving = moving;
        if (!moving && (w_mag > deadzone))
            r_res.moving = 1'b1;
        else if (moving && (w_mag <= stop_band))
            r_res.moving = 1'b0;
        if (!r_res.moving)
            r_res.move = MOVE_NONE;
        else if (err > 11'sd0)
            r_res.move = MOVE_DOWN;
        else
            r_res.move = MOVE_UP;
        return r_res;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that steps only when advance is high.
// Loads seed on reset; a nonzero seed keeps it out of the all-zero lock-up state.
module lfsr8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] r_q;
    logic       w_fb;

    assign w_fb = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];

    // NOTE: non-blocking assignment, so the shift and feedback both use pre-edge bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_q <= seed;
        else if (advance)
            r_q <= {r_q[6:0], w_fb};
    end

    assign q = r_q;

endmodule

// File: rtl/ai_paddle_controller.sv
// Computer opponent for the right paddle: reaction delay, dead-zone hysteresis,
// return-to-centre while the ball recedes, and LFSR-driven deliberate misses.
module ai_paddle_controller
    import pong_pkg::*;
#(
    parameter int         REACT_FRAMES = 4,
    parameter int         DEADZONE     = 6,
    parameter int         STOP_BAND    = 2,
    parameter int         CENTER_Y     = 250,
    parameter int         BALL_SIZE    = 10,
    parameter int         MISS_LOG2    = 3,
    parameter logic [7:0] SEED         = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       enable,
    input  logic [9:0] ball_y,
    input  logic [9:0] ball_dx,
    input  logic [9:0] paddle_y,
    input  logic [9:0] paddle_height,
    output logic [1:0] move,
    output logic [1:0] ai_state
);

    localparam int          CNT_W     = (REACT_FRAMES > 1) ? $clog2(REACT_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((REACT_FRAMES > 0) ? REACT_FRAMES - 1 : 0);
    localparam logic [10:0] DZ        = 11'(DEADZONE);
    localparam logic [10:0] SB        = 11'(STOP_BAND);
    localparam logic [10:0] CENTRE    = 11'(CENTER_Y);
    localparam logic [10:0] HALF_BALL = 11'(BALL_SIZE / 2);
    localparam logic [7:0]  MISS_MASK = 8'((1 << MISS_LOG2) - 1);

    ai_state_t          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_moving;
    logic [1:0]         r_move;

    logic [7:0]         w_lfsr;
    logic               w_approach;
    logic               w_miss;
    logic [10:0]        w_paddle_c;
    logic [10:0]        w_target_trk;
    logic signed [10:0] w_err_idle;
    logic signed [10:0] w_err_trk;
    hyst_t              w_idl;
    hyst_t              w_trk;

    lfsr8 u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (frame_tick),
        .seed    (SEED),
        .q       (w_lfsr)
    );

    // A stationary ball (dx == 0) counts as receding.
    assign w_approach   = !ball_dx[9] && (ball_dx != 10'd0);
    assign w_miss       = (MISS_LOG2 > 0) && ((w_lfsr & MISS_MASK) == 8'd0);

    assign w_paddle_c   = {1'b0, paddle_y} + {1'b0, (paddle_height >> 1)};
    assign w_target_trk = {1'b0, ball_y} + HALF_BALL;
    assign w_err_idle   = CENTRE - w_paddle_c;
    assign w_err_trk    = w_target_trk - w_paddle_c;

    // Hysteresis results for both targets; the FSM picks by the state it moves into.
    assign w_idl = hyst_step(r_moving, w_err_idle, DZ, SB);
    assign w_trk = hyst_step(r_moving, w_err_trk, DZ, SB);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= AI_IDLE;
            r_cnt    <= '0;
            r_moving <= 1'b0;
            r_move   <= MOVE_NONE;
        end else if (frame_tick) begin
            if (!enable) begin
                r_state  <= AI_IDLE;
                r_moving <= 1'b0;
                r_move   <= MOVE_NONE;
            end else begin
                unique case (r_state)
                    AI_IDLE: begin
                        if (!w_approach) begin
                            r_moving <= w_idl.moving;
                            r_move   <= w_idl.move;
                        end else if (REACT_FRAMES == 0 && !w_miss) begin
                            r_state  <= AI_TRACK;
                            r_moving <= w_trk.moving;
                            r_move   <= w_trk.move;
                        end else begin
                            r_state  <= (REACT_FRAMES == 0) ? AI_MISS : AI_REACT;
                            r_cnt    <= CNT_INIT;
                            r_moving <= 1'b0;
                            r_move   <= MOVE_NONE;
                        end
                    end
                    AI_REACT: begin
                        if (!w_approach) begin
                            r_state  <= AI_IDLE;
                            r_moving <= w_idl.moving;
                            r_move   <= w_idl.move;
                        end else if (r_cnt != '0) begin
                            r_cnt    <= r_cnt - CNT_W'(1);
                            r_move   <= MOVE_NONE;
                        end else if (w_miss) begin
                            r_state  <= AI_MISS;
                            r_moving <= 1'b0;
                            r_move   <= MOVE_NONE;
                        end else begin
                            r_state  <= AI_TRACK;
                            r_moving <= w_trk.moving;
                            r_move   <= w_trk.move;
                        end
                    end
                    AI_TRACK: begin
                        if (!w_approach) begin
                            r_state  <= AI_IDLE;
                            r_moving <= w_idl.moving;
                            r_move   <= w_idl.move;
                        end else begin
                            r_moving <= w_trk.moving;
                            r_move   <= w_trk.move;
                        end
                    end
                    AI_MISS: begin
                        if (!w_approach) begin
                            r_state  <= AI_IDLE;
                            r_moving <= w_idl.moving;
                            r_move   <= w_idl.move;
                        end else begin
                            r_moving <= 1'b0;
                            r_move   <= MOVE_NONE;
                        end
                    end
                    default: begin
                        r_state  <= AI_IDLE;
                        r_moving <= 1'b0;
                        r_move   <= MOVE_NONE;
                    end
                endcase
            end
        end
    end

    assign move     = r_move;
    assign ai_state = r_state;

endmodule

// File: tb/tb_ai_paddle_controller.sv
// Self-checking bench for ai_paddle_controller: directed scenarios followed by a
// randomized game walk, every tick compared against a behavioural opponent model.
module tb_ai_paddle_controller;

    localparam int         REACT_FRAMES = 4;
    localparam int         DEADZONE     = 6;
    localparam int         STOP_BAND    = 2;
    localparam int         CENTER_Y     = 250;
    localparam int         BALL_SIZE    = 10;
    localparam int         MISS_LOG2    = 3;
    localparam logic [7:0] SEED         = 8'hA5;

    localparam int S_IDLE = 0, S_REACT = 1, S_TRACK = 2, S_MISS = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       enable = 1'b0;
    logic [9:0] ball_y = '0;
    logic [9:0] ball_dx = '0;
    logic [9:0] paddle_y = '0;
    logic [9:0] paddle_height = '0;
    logic [1:0] move;
    logic [1:0] ai_state;

    ai_paddle_controller #(
        .REACT_FRAMES (REACT_FRAMES),
        .DEADZONE     (DEADZONE),
        .STOP_BAND    (STOP_BAND),
        .CENTER_Y     (CENTER_Y),
        .BALL_SIZE    (BALL_SIZE),
        .MISS_LOG2    (MISS_LOG2),
        .SEED         (SEED)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .enable        (enable),
        .ball_y        (ball_y),
        .ball_dx       (ball_dx),
        .paddle_y      (paddle_y),
        .paddle_height (paddle_height),
        .move          (move),
        .ai_state      (ai_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural opponent: phase, frames left to react, moving flag, random byte.
    int         m_state;
    int         m_wait;
    bit         m_moving;
    logic [7:0] m_rand;
    logic [1:0] m_move;

    function automatic logic [7:0] rand_next(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    function automatic bit misses(input logic [7:0] v);
        return (MISS_LOG2 > 0) && ((int'(v) % (1 << MISS_LOG2)) == 0);
    endfunction

    // Would a volley that starts on the next tick end in a miss?
    function automatic bit volley_misses(input logic [7:0] v);
        logic [7:0] x;
        x = v;
        for (int i = 0; i < REACT_FRAMES; i++) x = rand_next(x);
        return misses(x);
    endfunction

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_state  = S_IDLE;
        m_wait   = 0;
        m_moving = 1'b0;
        m_rand   = SEED;
        m_move   = 2'b00;
    endtask

    task automatic model_step();
        bit approaching;
        int next;
        int err;
        int mag;
        approaching = (ball_dx != 10'd0) && (int'($signed(ball_dx)) > 0);
        next = m_state;
        if (!enable) begin
            next = S_IDLE;
        end else if (!approaching) begin
            next = S_IDLE;
        end else if (m_state == S_IDLE) begin
            if (REACT_FRAMES == 0) next = misses(m_rand) ? S_MISS : S_TRACK;
            else begin
                next   = S_REACT;
                m_wait = REACT_FRAMES - 1;
            end
        end else if (m_state == S_REACT) begin
            if (m_wait == 0) next = misses(m_rand) ? S_MISS : S_TRACK;
            else m_wait = m_wait - 1;
        end
        if (!enable || next == S_REACT || next == S_MISS) begin
            m_moving = 1'b0;
            m_move   = 2'b00;
        end else begin
            err = ((next == S_TRACK) ? int'(ball_y) + BALL_SIZE / 2 : CENTER_Y)
                  - (int'(paddle_y) + int'(paddle_height) / 2);
            mag = (err < 0) ? -err : err;
            if (!m_moving && mag > DEADZONE) m_moving = 1'b1;
            else if (m_moving && mag <= STOP_BAND) m_moving = 1'b0;
            m_move = !m_moving ? 2'b00 : ((err > 0) ? 2'b01 : 2'b10);
        end
        m_state = next;
        m_rand  = rand_next(m_rand);
    endtask

    task automatic tick(input string tag);
        @(negedge clk);
        model_step();
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        check({tag, "_move"}, 16'(move), 16'(m_move));
        check({tag, "_state"}, 16'(ai_state), 16'(m_state));
    endtask

    // Idle receding ticks until the next volley's miss outcome is the one wanted.
    task automatic steer(input bit want_miss);
        int n;
        n = 0;
        ball_dx = 10'h3FE;
        while (volley_misses(m_rand) != want_miss && n < 300) begin
            tick("steer");
            n++;
        end
        check("steer_bound", 16'(n < 300), 16'd1);
    endtask

    task automatic set_dx(input int v);
        ball_dx = 10'(v);
    endtask

    initial begin
        bit  dir;
        int  by;
        int  py;
        model_reset();

        // Reset held while ticks arrive: nothing moves.
        enable        = 1'b1;
        paddle_height = 10'd50;
        paddle_y      = 10'd100;
        set_dx(-2);
        repeat (3) begin
            @(negedge clk);
            frame_tick = 1'b1;
            @(posedge clk);
            #1;
            frame_tick = 1'b0;
        end
        check("rst_move", 16'(move), 16'd0);
        check("rst_state", 16'(ai_state), 16'd0);

        @(negedge clk);
        reset = 1'b1;
        ball_y = 10'd200;
        tick("centre");
        check("centre_down", 16'(move), 16'b01);

        // Reaction delay then tracking.
        steer(1'b0);
        ball_y   = 10'd300;
        paddle_y = 10'd100;
        set_dx(2);
        for (int i = 1; i <= REACT_FRAMES; i++) begin
            tick("react");
            check("react_state", 16'(ai_state), 16'd1);
            check("react_move", 16'(move), 16'd0);
        end
        tick("track_entry");
        check("track_state", 16'(ai_state), 16'd2);
        check("track_move", 16'(move), 16'b01);

        // Hysteresis: errors 0, +7, +4, +2, +5, -7.
        paddle_y = 10'd200;
        ball_y = 10'd220; tick("hys0");  check("hys_e0", 16'(move), 16'b00);
        ball_y = 10'd227; tick("hys1");  check("hys_p7", 16'(move), 16'b01);
        ball_y = 10'd224; tick("hys2");  check("hys_p4", 16'(move), 16'b01);
        ball_y = 10'd222; tick("hys3");  check("hys_p2", 16'(move), 16'b00);
        ball_y = 10'd225; tick("hys4");  check("hys_p5", 16'(move), 16'b00);
        ball_y = 10'd213; tick("hys5");  check("hys_m7", 16'(move), 16'b10);

        // Outputs hold between ticks.
        repeat (3) @(posedge clk);
        #1;
        check("hold_move", 16'(move), 16'b10);
        check("hold_state", 16'(ai_state), 16'd2);

        // Disable mid-volley.
        enable = 1'b0;
        tick("disable");
        check("dis_state", 16'(ai_state), 16'd0);
        check("dis_move", 16'(move), 16'd0);
        enable = 1'b1;

        // Reversal during the reaction window.
        steer(1'b0);
        set_dx(2);
        tick("rev1");
        tick("rev2");
        check("rev_react", 16'(ai_state), 16'd1);
        set_dx(-2);
        tick("rev3");
        check("rev_idle", 16'(ai_state), 16'd0);
        tick("rev4");
        check("rev_stay", 16'(ai_state), 16'd0);

        // Deliberate miss for a whole volley.
        steer(1'b1);
        set_dx(2);
        ball_y = 10'd400;
        paddle_y = 10'd100;
        for (int i = 0; i < REACT_FRAMES; i++) tick("miss_react");
        tick("miss_entry");
        check("miss_state", 16'(ai_state), 16'd3);
        check("miss_move", 16'(move), 16'd0);
        for (int i = 0; i < 3; i++) begin
            ball_y = 10'(60 + 100 * i);
            tick("miss_hold");
            check("miss_hold_move", 16'(move), 16'd0);
        end
        set_dx(-2);
        tick("miss_exit");
        check("miss_exit", 16'(ai_state), 16'd0);

        // Asynchronous reset between ticks, away from any rising edge.
        steer(1'b0);
        set_dx(2);
        ball_y = 10'd400;
        for (int i = 0; i <= REACT_FRAMES; i++) tick("pre_areset");
        check("pre_areset_move", 16'(move), 16'b01);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("areset_move", 16'(move), 16'd0);
        check("areset_state", 16'(ai_state), 16'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // Randomized game walk.
        dir = 1'b1;
        by  = 250;
        py  = 200;
        for (int i = 0; i < 600; i++) begin
            int mag;
            if ($urandom_range(0, 7) == 0) dir = !dir;
            mag = $urandom_range(0, 7);
            set_dx(dir ? mag : -mag);
            by = by + $urandom_range(0, 16) - 8;
            py = py + $urandom_range(0, 12) - 6;
            if (by < 0) by = 0;
            if (by > 600) by = 600;
            if (py < 0) py = 0;
            if (py > 500) py = 500;
            ball_y = 10'(by);
            paddle_y = 10'(py);
            if ($urandom_range(0, 31) == 0) paddle_height = 10'($urandom_range(20, 100));
            enable = ($urandom_range(0, 19) != 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
